// File: rtl/mod_12_pkg.sv
// Shared definitions for the mod-12 counter family: default range, bus width,
// monitor state encoding and the step classes produced by the classifier.
package mod_12_pkg;

    localparam int MAX_DEFAULT = 12;
    localparam int CW_DEFAULT  = 4;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        FAULT
    } state_e;

    typedef enum logic [2:0] {
        HOLD,
        UP,
        DN,
        WRAP_UP,
        WRAP_DN,
        JUMP,
        ILLEGAL
    } step_class_e;

endpackage

// File: rtl/mod_12_step_classifier.sv
// Combinational classification of a new count sample against the previous one.
// The first matching case wins, so wraps and single steps are never reported as jumps.
module mod_12_step_classifier
    import mod_12_pkg::*;
#(
    parameter int MAX = MAX_DEFAULT,
    parameter int CW  = CW_DEFAULT
) (
    input  logic [CW-1:0] prev_i,
    input  logic [CW-1:0] sample_i,
    output step_class_e   class_o
);

    // One extra bit keeps p+1 and p-1 from overflowing at the range ends.
    localparam logic [CW:0] MAX_EXT = (CW+1)'(MAX);
    localparam logic [CW:0] ONE     = (CW+1)'(1);

    logic [CW:0] p;
    logic [CW:0] s;

    assign p = {1'b0, prev_i};
    assign s = {1'b0, sample_i};

    always_comb begin
        class_o = JUMP;
        if (s > MAX_EXT) begin
            class_o = ILLEGAL;
        end else if (s == p) begin
            class_o = HOLD;
        end else if ((p < MAX_EXT) && (s == p + ONE)) begin
            class_o = UP;
        end else if ((p == MAX_EXT) && (s == '0)) begin
            class_o = WRAP_UP;
        end else if ((p != '0) && (s == p - ONE)) begin
            class_o = DN;
        end else if ((p == '0) && (s == MAX_EXT)) begin
            class_o = WRAP_DN;
        end
    end

endmodule

// File: rtl/mod_12_count_monitor.sv
// Receive-side monitor for the mod-12 up/down counter: decodes steps, wraps,
// loads, stalls and illegal values, and keeps a saturating signed revolution count.
module mod_12_count_monitor
    import mod_12_pkg::*;
#(
    parameter int MAX         = MAX_DEFAULT,
    parameter int CW          = CW_DEFAULT,
    parameter int WRAP_W      = 8,
    parameter int STALL_LIMIT = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cnt_valid,
    input  logic [CW-1:0]            count,
    input  logic                     clear_err,
    output logic                     dir,
    output logic                     step,
    output logic                     wrap_up,
    output logic                     wrap_dn,
    output logic                     jump,
    output logic                     stall,
    output logic                     err,
    output logic signed [WRAP_W-1:0] revs
);

    localparam int                       SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]            STALL_MAX = SW'(STALL_LIMIT);
    localparam logic [SW-1:0]            STALL_ONE = SW'(1);
    localparam logic signed [WRAP_W-1:0] REVS_MAX  = {1'b0, {(WRAP_W-1){1'b1}}};
    localparam logic signed [WRAP_W-1:0] REVS_MIN  = {1'b1, {(WRAP_W-1){1'b0}}};
    localparam logic signed [WRAP_W-1:0] REVS_ONE  = WRAP_W'(1);

    state_e                     state_q, state_d;
    logic [CW-1:0]              prev_q, prev_d;
    logic                       dir_q, dir_d;
    logic                       step_q, step_d;
    logic                       wrapUp_q, wrapUp_d;
    logic                       wrapDn_q, wrapDn_d;
    logic                       jump_q, jump_d;
    logic                       stall_q, stall_d;
    logic [SW-1:0]              stallCnt_q, stallCnt_d;
    logic                       err_q, err_d;
    logic signed [WRAP_W-1:0]   revs_q, revs_d;
    step_class_e                stepClass;

    mod_12_step_classifier #(
        .MAX (MAX),
        .CW  (CW)
    ) u_classifier (
        .prev_i   (prev_q),
        .sample_i (count),
        .class_o  (stepClass)
    );

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        dir_d      = dir_q;
        step_d     = 1'b0;
        wrapUp_d   = 1'b0;
        wrapDn_d   = 1'b0;
        jump_d     = 1'b0;
        stall_d    = stall_q;
        stallCnt_d = stallCnt_q;
        err_d      = err_q;
        revs_d     = revs_q;

        // clear_err discards the sample of its own cycle; dir deliberately survives it.
        if (clear_err) begin
            state_d    = INIT;
            err_d      = 1'b0;
            revs_d     = '0;
            stall_d    = 1'b0;
            stallCnt_d = '0;
        end else if (cnt_valid) begin
            case (state_q)
                INIT: begin
                    if (stepClass == ILLEGAL) begin
                        err_d   = 1'b1;
                        state_d = FAULT;
                    end else begin
                        prev_d  = count;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    case (stepClass)
                        ILLEGAL: begin
                            err_d   = 1'b1;
                            state_d = FAULT;
                        end
                        HOLD: begin
                            if (stallCnt_q != STALL_MAX) begin
                                stallCnt_d = stallCnt_q + STALL_ONE;
                            end
                            stall_d = (stallCnt_d == STALL_MAX);
                        end
                        default: begin
                            prev_d     = count;
                            stallCnt_d = '0;
                            stall_d    = 1'b0;
                            case (stepClass)
                                UP: begin
                                    step_d = 1'b1;
                                    dir_d  = 1'b1;
                                end
                                WRAP_UP: begin
                                    step_d   = 1'b1;
                                    wrapUp_d = 1'b1;
                                    dir_d    = 1'b1;
                                    if (revs_q != REVS_MAX) begin
                                        revs_d = revs_q + REVS_ONE;
                                    end
                                end
                                DN: begin
                                    step_d = 1'b1;
                                    dir_d  = 1'b0;
                                end
                                WRAP_DN: begin
                                    step_d   = 1'b1;
                                    wrapDn_d = 1'b1;
                                    dir_d    = 1'b0;
                                    if (revs_q != REVS_MIN) begin
                                        revs_d = revs_q - REVS_ONE;
                                    end
                                end
                                default: begin
                                    jump_d = 1'b1;
                                end
                            endcase
                        end
                    endcase
                end
                FAULT: begin
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            prev_q     <= '0;
            dir_q      <= 1'b1;
            step_q     <= 1'b0;
            wrapUp_q   <= 1'b0;
            wrapDn_q   <= 1'b0;
            jump_q     <= 1'b0;
            stall_q    <= 1'b0;
            stallCnt_q <= '0;
            err_q      <= 1'b0;
            revs_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            wrapUp_q   <= wrapUp_d;
            wrapDn_q   <= wrapDn_d;
            jump_q     <= jump_d;
            stall_q    <= stall_d;
            stallCnt_q <= stallCnt_d;
            err_q      <= err_d;
            revs_q     <= revs_d;
        end
    end

    assign dir     = dir_q;
    assign step    = step_q;
    assign wrap_up = wrapUp_q;
    assign wrap_dn = wrapDn_q;
    assign jump    = jump_q;
    assign stall   = stall_q;
    assign err     = err_q;
    assign revs    = revs_q;

endmodule

// File: tb/tb_mod_12_count_monitor.sv
// Scoreboard bench for mod_12_count_monitor: each applied cycle queues its expected
// registered outputs, and a negedge monitor compares them one cycle later.
module tb_mod_12_count_monitor;

    localparam int WRAP_W = 4;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     cntValid = 1'b0;
    logic [3:0]               count = '0;
    logic                     clearErr = 1'b0;
    logic                     dir, step, wrapUp, wrapDn, jump, stall, err;
    logic signed [WRAP_W-1:0] revs;

    typedef logic [6+WRAP_W:0] obs_t;
    obs_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;

    mod_12_count_monitor #(
        .MAX         (12),
        .CW          (4),
        .WRAP_W      (WRAP_W),
        .STALL_LIMIT (15)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cnt_valid (cntValid),
        .count     (count),
        .clear_err (clearErr),
        .dir       (dir),
        .step      (step),
        .wrap_up   (wrapUp),
        .wrap_dn   (wrapDn),
        .jump      (jump),
        .stall     (stall),
        .err       (err),
        .revs      (revs)
    );

    always #5 clock = ~clock;

    // Drive one cycle and queue the outputs expected after its rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic clr,
                                 input logic [3:0] c, input logic eDir, input logic eStep,
                                 input logic eWu, input logic eWd, input logic eJump,
                                 input logic eStall, input logic eErr, input int eRevs);
        reset    = rst;
        cntValid = v;
        clearErr = clr;
        count    = c;
        expQ.push_back({eDir, eStep, eWu, eWd, eJump, eStall, eErr, WRAP_W'(eRevs)});
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input obs_t expected);
        obs_t actual;
        actual = {dir, step, wrapUp, wrapDn, jump, stall, err, revs};
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL vec%0d {dir,step,wu,wd,jump,stall,err,revs}: got %b expected %b",
                     vectors, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        int rv;

        applyStimulus(1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);

        // First sample only loads; then up steps including a MAX->0 wrap.
        applyStimulus(0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 11, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 12, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 1);

        applyStimulus(0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 12, 0, 1, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 11, 0, 1, 0, 0, 0, 0, 0, 0);

        // Jumps keep direction; adjacent values after them are ordinary steps.
        applyStimulus(0, 1, 0, 2,  0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 3,  1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 9,  1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 8,  0, 1, 0, 0, 0, 0, 0, 0);

        // Sixteen samples of 5 (one invalid cycle inside); stall on the 15th repeat.
        applyStimulus(0, 1, 0, 5,  0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) begin
                applyStimulus(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            applyStimulus(0, 1, 0, 5, 0, 0, 0, 0, 0, (k >= 15), 0, 0);
        end
        applyStimulus(0, 1, 0, 6,  1, 1, 0, 0, 0, 0, 0, 0);

        // Illegal value freezes everything until clear_err.
        applyStimulus(0, 1, 0, 12, 1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 1,  1, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0,  0, 1, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 14, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 1, 1, 13, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0,  1, 1, 1, 0, 0, 0, 0, 1);

        // Eight up-revolutions with a gap in each; revs saturates at +7.
        rv = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 1; i <= 12; i++) begin
                if (i == 6) begin
                    applyStimulus(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, rv);
                end
                applyStimulus(0, 1, 0, 4'(i), 1, 1, 0, 0, 0, 0, 0, rv);
            end
            rv = (rv < 7) ? rv + 1 : 7;
            applyStimulus(0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, rv);
        end

        // Seventeen down-revolutions; revs saturates at -8.
        for (int r = 0; r < 17; r++) begin
            rv = (rv > -8) ? rv - 1 : -8;
            applyStimulus(0, 1, 0, 12, 0, 1, 0, 1, 0, 0, 0, rv);
            for (int i = 11; i >= 0; i--) begin
                applyStimulus(0, 1, 0, 4'(i), 0, 1, 0, 0, 0, 0, 0, rv);
            end
        end

        // Illegal first sample straight out of reset.
        applyStimulus(1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 15, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 1, 0, 3,  1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 4,  1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 5,  1, 1, 0, 0, 0, 0, 0, 0);

        cntValid = 1'b0;
        repeat (3) @(negedge clock);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_12_count_monitor.md
Name: mod_12_count_monitor

Overview:
Receive-side companion to the loadable mod-12 up/down counter. Samples the counter's count bus and decodes direction, single steps, wrap-arounds, load jumps, stalls and illegal values. Keeps a signed revolution count. Sits downstream of the counter, e.g. for sequence checking or for driving a 12-hour/day rollover stage.

Parameters:
MAX, 12, highest legal count value; legal range 0..MAX inclusive; up wraps MAX->0, down wraps 0->MAX
CW, 4, count bus width; must satisfy 2**CW > MAX
WRAP_W, 8, width of signed revolution counter
STALL_LIMIT, 15, consecutive unchanged valid samples before stall asserts

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cnt_valid  in  1  count is sampled only in cycles where this is 1
count  in  CW  count value from the counter
clear_err  in  1  clears fault, revolution count and tracking
dir  out  1  last decoded direction: 1 = up, 0 = down
step  out  1  one-cycle pulse on a legal +/-1 step, wraps included
wrap_up  out  1  one-cycle pulse on a MAX->0 transition
wrap_dn  out  1  one-cycle pulse on a 0->MAX transition
jump  out  1  one-cycle pulse on a legal, non-adjacent, changed value (load)
stall  out  1  level; unchanged for STALL_LIMIT or more valid samples
err  out  1  sticky illegal-value flag
revs  out  WRAP_W  signed revolution count

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state = INIT; prev = 0; dir = 1
  - step, wrap_up, wrap_dn, jump = 0
  - stall = 0; stall counter = 0; err = 0; revs = 0
- All outputs are registered. Pulses appear in the cycle after the classifying sample, so latency is 1 cycle. Pulses are 0 in any cycle with no classification.
- Cycles with cnt_valid = 0: no classification, no pulses. prev and the stall counter hold.
- Priority: reset > clear_err > sample. When clear_err = 1:
  - state -> INIT, err = 0, revs = 0, stall = 0, stall counter = 0
  - that cycle's sample is ignored
  - dir holds
- States:
  - INIT: first valid sample s <= MAX loads prev = s, state -> TRACK, no pulses. A valid s > MAX sets err = 1 and moves to FAULT.
  - TRACK: each valid sample s is compared with prev p, in this order:
    1. s > MAX: err = 1, state -> FAULT, prev unchanged.
    2. s == p: hold. Stall counter increments and saturates at STALL_LIMIT. stall = 1 once the counter reaches STALL_LIMIT.
    3. p < MAX and s == p+1: step = 1, dir = 1.
    4. p == MAX and s == 0: step = 1, wrap_up = 1, dir = 1, revs + 1.
    5. p > 0 and s == p-1: step = 1, dir = 0.
    6. p == 0 and s == MAX: step = 1, wrap_dn = 1, dir = 0, revs - 1.
    7. Otherwise: jump = 1, dir unchanged.
    - Cases 3-7: prev = s, stall counter = 0, stall = 0.
  - FAULT: all pulses suppressed; samples ignored; err stays 1; revs, dir and stall frozen. Exit only via clear_err (to INIT) or reset.
- revs: two's-complement, saturating at +(2**(WRAP_W-1)-1) and -(2**(WRAP_W-1)). No wrap-around.
- Arithmetic: the p+1 / p-1 comparisons use CW+1 bits so that no comparison overflows.

Decomposition:
- Shared package mod_12_pkg holds:
  - state enumeration (INIT, TRACK, FAULT)
  - MAX_DEFAULT = 12 and CW_DEFAULT = 4, so the counter and the monitor share one definition
  - a step-class enumeration: HOLD, UP, DN, WRAP_UP, WRAP_DN, JUMP, ILLEGAL
- One natural sub-module, mod_12_step_classifier: purely combinational (p, s) -> step class. It is reused by the checker bench.
- The state machine, stall counter and revs counter stay in the top module.

Test Plan:
- Reset, then valid samples 10, 11, 12, 0, 1 -> no pulse on 10. step on each later sample. wrap_up on the 12->0 sample. revs = 1. dir = 1.
- From prev = 1, samples 0, 12, 11 -> step x3. wrap_dn on the 0->12 sample. revs decrements by 1. dir = 0.
- From prev = 3, sample 9 -> jump = 1, step = 0, dir unchanged. Next sample 8 -> step, dir = 0.
- Hold count = 5 for 16 valid samples -> stall rises the cycle after the 16th sample (15th repeat). Sample 6 -> stall = 0, step = 1.
- Sample 14 in TRACK -> err = 1 and FAULT. Later samples 0 and 1 give no pulses. Assert clear_err together with sample 13 -> err = 0, revs = 0, state INIT, sample 13 ignored.
- WRAP_W = 4: drive 8 up-wraps -> revs saturates at 7. Toggle cnt_valid = 0 mid-sequence -> prev holds, no spurious pulses.
